// File: rtl/boot_ctrl.sv
// boot_ctrl: streams a program into instruction memory, releases the core and supervises its run.
// Optional run-cycle watchdog enabled by defining BOOT_CTRL_TIMEOUT_EN.
module boot_ctrl #(
  parameter int unsigned D       = 10,
  parameter int unsigned W       = 9,
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         restart,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [W-1:0] ld_data,
  input  logic         ld_last,
  output logic         im_wr_en,
  output logic [D-1:0] im_addr,
  output logic [W-1:0] im_wr_data,
  output logic         core_reset,
  input  logic         core_done,
  output logic [D:0]   words_loaded,
  output logic [15:0]  cycle_cnt,
  output logic         run_ok,
  output logic         run_timeout
);

  localparam logic [D:0] DEPTH    = {1'b1, {D{1'b0}}};
  localparam logic [D:0] LAST_IDX = DEPTH - (D+1)'(1);
`ifdef BOOT_CTRL_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_LOAD, S_RELEASE, S_RUN, S_DONE, S_TOUT} state_e;

  state_e       state_q, state_d;
  logic         ready_q, ready_d;
  logic         wr_en_q, wr_en_d;
  logic [D-1:0] addr_q, addr_d;
  logic [W-1:0] data_q, data_d;
  logic         core_rst_q, core_rst_d;
  logic [D:0]   words_q, words_d;
  logic [15:0]  cycle_q, cycle_d;
  logic         ok_q, ok_d;
  logic         tout_q, tout_d;
  logic         accept_c;
  logic [15:0]  cycle_inc_c;

  assign accept_c    = ld_valid && ready_q;
  assign cycle_inc_c = (cycle_q == 16'hFFFF) ? cycle_q : cycle_q + 16'd1;

  // Next state; ready and core reset are registered from the next state so they track it exactly
  always_comb begin
    state_d = state_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    words_d = words_q;
    cycle_d = cycle_q;
    ok_d    = ok_q;
    tout_d  = tout_q;
    unique case (state_q)
      S_LOAD: begin
        if (accept_c) begin
          wr_en_d = 1'b1;
          addr_d  = words_q[D-1:0];
          data_d  = ld_data;
          words_d = words_q + (D+1)'(1);
          if (ld_last || (words_q == LAST_IDX)) state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_RUN;
      S_RUN: begin
        cycle_d = cycle_inc_c;
        // core_done takes priority over the watchdog limit
        if (core_done) begin
          state_d = S_DONE;
          ok_d    = 1'b1;
        end else if (TIMEOUT_EN && (cycle_inc_c >= TIMEOUT)) begin
          state_d = S_TOUT;
          tout_d  = 1'b1;
        end
      end
      S_DONE, S_TOUT: begin
        if (restart) begin
          state_d = S_LOAD;
          words_d = '0;
          cycle_d = '0;
          ok_d    = 1'b0;
          tout_d  = 1'b0;
        end
      end
      default: state_d = S_LOAD;
    endcase
    ready_d    = (state_d == S_LOAD) && (words_d < DEPTH);
    core_rst_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_LOAD;
      ready_q    <= 1'b1;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      core_rst_q <= 1'b1;
      words_q    <= '0;
      cycle_q    <= '0;
      ok_q       <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      core_rst_q <= core_rst_d;
      words_q    <= words_d;
      cycle_q    <= cycle_d;
      ok_q       <= ok_d;
      tout_q     <= tout_d;
    end
  end

  assign ld_ready     = ready_q;
  assign im_wr_en     = wr_en_q;
  assign im_addr      = addr_q;
  assign im_wr_data   = data_q;
  assign core_reset   = core_rst_q;
  assign words_loaded = words_q;
  assign cycle_cnt    = cycle_q;
  assign run_ok       = ok_q;
  assign run_timeout  = TIMEOUT_EN ? tout_q : 1'b0;

endmodule

// File: tb/tb_boot_ctrl.sv
// Scoreboard bench for boot_ctrl: expected memory writes are queued by stimulus and
// popped by a monitor on every im_wr_en; status is checked against hand-computed values.
module tb_boot_ctrl;

  localparam int unsigned D   = 3;
  localparam int unsigned W   = 9;
  localparam logic [15:0] TMO = 16'd20;
`ifdef BOOT_CTRL_TIMEOUT_EN
  localparam int DONE_AT = 15;
`else
  localparam int DONE_AT = 82;
`endif

  logic         clk, reset, restart, ld_valid, ld_ready, ld_last;
  logic [W-1:0] ld_data;
  logic         im_wr_en;
  logic [D-1:0] im_addr;
  logic [W-1:0] im_wr_data;
  logic         core_reset, core_done;
  logic [D:0]   words_loaded;
  logic [15:0]  cycle_cnt;
  logic         run_ok, run_timeout;

  int passed = 0;
  int total  = 0;
  logic [D+W-1:0] sb[$];
  logic [D+W-1:0] e;
  logic [D-1:0]   exp_addr;

  boot_ctrl #(.D(D), .W(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .im_wr_en(im_wr_en), .im_addr(im_addr), .im_wr_data(im_wr_data),
    .core_reset(core_reset), .core_done(core_done),
    .words_loaded(words_loaded), .cycle_cnt(cycle_cnt),
    .run_ok(run_ok), .run_timeout(run_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", nm, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic beat(input logic [W-1:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    sb.push_back({exp_addr, d});
    exp_addr = exp_addr + D'(1);
    step();
  endtask

  task automatic idle(input logic [W-1:0] junk);
    ld_valid = 1'b0;
    ld_data  = junk;
    ld_last  = 1'b1;
    step();
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart  = 1'b0;
    exp_addr = '0;
    at_neg();
    chk("rst_words", 32'(words_loaded), 0);
    chk("rst_cycles", 32'(cycle_cnt), 0);
    chk("rst_ok", 32'(run_ok), 0);
    chk("rst_tout", 32'(run_timeout), 0);
    chk("rst_ready", 32'(ld_ready), 1);
    chk("rst_core_reset", 32'(core_reset), 1);
  endtask

  // Monitor: every write the DUT presents must match the head of the scoreboard
  always @(negedge clk) begin
    if (im_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL wr_unexpected: got write addr=%0h data=%0h, required no write", im_addr, im_wr_data);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(im_addr), 32'(e[D+W-1:W]));
        chk("wr_data", 32'(im_wr_data), 32'(e[W-1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; restart = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    core_done = 1'b0; exp_addr = '0;
    at_neg();
    chk("reset_ready", 32'(ld_ready), 1);
    chk("reset_wr_en", 32'(im_wr_en), 0);
    chk("reset_addr", 32'(im_addr), 0);
    chk("reset_data", 32'(im_wr_data), 0);
    chk("reset_core_reset", 32'(core_reset), 1);
    chk("reset_words", 32'(words_loaded), 0);
    chk("reset_cycles", 32'(cycle_cnt), 0);
    chk("reset_ok", 32'(run_ok), 0);
    chk("reset_tout", 32'(run_timeout), 0);
    step(); step();
    reset = 1'b0;

    // core_done is ignored while loading
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    at_neg();
    chk("load_done_ign_ready", 32'(ld_ready), 1);
    chk("load_done_ign_ok", 32'(run_ok), 0);

    // Three words, valid held, last on the third
    beat(9'h1A0, 1'b0);
    beat(9'h055, 1'b0);
    beat(9'h1FF, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0;
    at_neg();
    chk("t1_words", 32'(words_loaded), 3);
    chk("t1_rel_ready", 32'(ld_ready), 0);
    chk("t1_rel_core_reset", 32'(core_reset), 1);
    chk("t1_rel_last_write", 32'(im_wr_en), 1);
    step();
    at_neg();
    chk("t1_run_core_reset", 32'(core_reset), 0);
    chk("t1_run_cycles0", 32'(cycle_cnt), 0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    at_neg();
    chk("t1_restart_ign", 32'(core_reset), 0);
    repeat (DONE_AT - 2) step();
    at_neg();
    chk("t1_pre_done_cycles", 32'(cycle_cnt), 32'(DONE_AT - 1));
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    at_neg();
    chk("t1_done_cycles", 32'(cycle_cnt), 32'(DONE_AT));
    chk("t1_done_ok", 32'(run_ok), 1);
    chk("t1_done_core_reset", 32'(core_reset), 1);
    chk("t1_done_tout", 32'(run_timeout), 0);
    step();
    at_neg();
    chk("t1_hold_cycles", 32'(cycle_cnt), 32'(DONE_AT));
    chk("t1_hold_words", 32'(words_loaded), 3);
    do_restart();

    // Toggling valid: only accepted beats write, addresses contiguous
    beat(9'h011, 1'b0);
    idle(9'h0AA);
    beat(9'h022, 1'b0);
    idle(9'h0BB);
    beat(9'h033, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0;
    at_neg();
    chk("t2_words", 32'(words_loaded), 3);
    step();
`ifdef BOOT_CTRL_TIMEOUT_EN
    repeat (19) step();
    at_neg();
    chk("t2_pre_limit_core_reset", 32'(core_reset), 0);
    chk("t2_pre_limit_cycles", 32'(cycle_cnt), 19);
    step();
    at_neg();
    chk("t2_tout_cycles", 32'(cycle_cnt), 20);
    chk("t2_tout_flag", 32'(run_timeout), 1);
    chk("t2_tout_core_reset", 32'(core_reset), 1);
    chk("t2_tout_ok", 32'(run_ok), 0);
    step();
    at_neg();
    chk("t2_tout_hold", 32'(cycle_cnt), 20);
    do_restart();
    beat(9'h100, 1'b0);
    beat(9'h101, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0;
    step();
    repeat (19) step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    at_neg();
    chk("t2_tie_ok", 32'(run_ok), 1);
    chk("t2_tie_tout", 32'(run_timeout), 0);
    chk("t2_tie_cycles", 32'(cycle_cnt), 20);
`else
    repeat (29) step();
    at_neg();
    chk("t2_no_tout_cycles", 32'(cycle_cnt), 29);
    chk("t2_no_tout_core_reset", 32'(core_reset), 0);
    chk("t2_no_tout_flag", 32'(run_timeout), 0);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    at_neg();
    chk("t2_done_cycles", 32'(cycle_cnt), 30);
    chk("t2_done_ok", 32'(run_ok), 1);
`endif
    do_restart();

    // Fill all 2^D words without last; load ends with no wrap-around
    for (int i = 0; i < 8; i++) beat(9'(9'h0C0 + i), 1'b0);
    ld_data = 9'h1EE;
    at_neg();
    chk("t3_full_ready", 32'(ld_ready), 0);
    chk("t3_full_words", 32'(words_loaded), 8);
    chk("t3_full_core_reset", 32'(core_reset), 1);
    step();
    ld_valid = 1'b0;
    at_neg();
    chk("t3_run_core_reset", 32'(core_reset), 0);
    chk("t3_run_words", 32'(words_loaded), 8);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    at_neg();
    chk("t3_done_cycles", 32'(cycle_cnt), 1);
    do_restart();

    // Reset mid-load with a beat pending
    beat(9'h101, 1'b0);
    beat(9'h102, 1'b0);
    ld_valid = 1'b0;
    step();
    ld_valid = 1'b1; ld_data = 9'h1DD; ld_last = 1'b0;
    #1 reset = 1'b1;
    at_neg();
    chk("t4_rst_wr_en", 32'(im_wr_en), 0);
    chk("t4_rst_words", 32'(words_loaded), 0);
    chk("t4_rst_ready", 32'(ld_ready), 1);
    chk("t4_rst_core_reset", 32'(core_reset), 1);
    step();
    reset = 1'b0; ld_valid = 1'b0; exp_addr = '0;
    at_neg();
    chk("t4_after_wr_en", 32'(im_wr_en), 0);
    chk("t4_after_words", 32'(words_loaded), 0);
    beat(9'h0F0, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0;
    at_neg();
    chk("t4_reload_words", 32'(words_loaded), 1);
    step(); step();
    chk("sb_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
